mem_copy_engine: RTL and testbench

Memory-access initiator that drives the 256×8 byte memory's port (`memory_addr`, `memory_read_enable`, `memory_write_enable`, `memory_write_data`) and consumes `memory_read_data`. On a start request it either copies a block from a source address to a destination address, or fills a destination block with a constant. It also reports an 8-bit modular checksum of the bytes written. It sits between the control unit and the memory and is the memory's only master while busy.

---
 rtl/mem_copy_engine_if.sv | 28 ++
 rtl/mem_copy_engine.sv | 183 ++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Byte-wide memory port between the copy engine and the memory.
// master: engine drives addr/strobes/wdata; slave: memory returns rdata.
interface mem_copy_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] memory_addr;
  logic              memory_read_enable;
  logic              memory_write_enable;
  logic [DATA_W-1:0] memory_write_data;
  logic [DATA_W-1:0] memory_read_data;

  modport master (
    output memory_addr,
    output memory_read_enable,
    output memory_write_enable,
    output memory_write_data,
    input  memory_read_data
  );

  modport slave (
    input  memory_addr,
    input  memory_read_enable,
    input  memory_write_enable,
    input  memory_write_data,
    output memory_read_data
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / fill initiator for a byte memory with running checksum.
// Ports: clk, rst_n, start/mode/src/dst/length/fill request, mem bus, busy/done/checksum.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic [DATA_W-1:0]   fill_value,
  mem_copy_engine_if.master   mem,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CAPT  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  logic last;
  assign last = (rem_q == {{(ADDR_W-1){1'b0}}, 1'b1});

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && (length != '0)) begin
          state_d = mode ? WRITE : READ;
        end
      end
      READ:  state_d = CAPT;
      CAPT:  state_d = WRITE;
      WRITE: begin
        if (last) begin
          state_d = IDLE;
        end else if (mode_q) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
    endcase
  end

  // Datapath and registered outputs. The first case updates the
  // working registers for the current state; the second sets the
  // strobes for the state being entered so they appear right after
  // the edge that enters it.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    addr_d  = addr_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    csum_d  = csum_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = length;
          mode_d = mode;
          fill_d = fill_value;
          csum_d = '0;
          done_d = (length == '0);
        end
      end
      READ: begin
      end
      CAPT: begin
        wdata_d = mem.memory_read_data;
      end
      WRITE: begin
        csum_d = csum_q + wdata_q;
        src_d  = src_q + 1'b1;
        dst_d  = dst_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        done_d = last;
      end
    endcase

    unique case (state_d)
      IDLE: begin
      end
      READ: begin
        addr_d = src_d;
        re_d   = 1'b1;
        busy_d = 1'b1;
      end
      CAPT: begin
        busy_d = 1'b1;
      end
      WRITE: begin
        addr_d = dst_d;
        we_d   = 1'b1;
        busy_d = 1'b1;
        if (mode_d) begin
          wdata_d = fill_d;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csum_q  <= '0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      csum_q  <= csum_d;
    end
  end

  assign mem.memory_addr         = addr_q;
  assign mem.memory_read_enable  = re_q;
  assign mem.memory_write_enable = we_q;
  assign mem.memory_write_data   = wdata_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign checksum                = csum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 256x8 registered-read memory.
// Checks copy, fill, wrap, zero length, start while busy, reset, overlap.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic [7:0] fill_value;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  always #5 clk = ~clk;

  mem_copy_engine_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_wa;
  logic [7:0] tb_wd;

  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (bus.memory_write_enable)
      mem[bus.memory_addr] <= bus.memory_write_data;
    if (bus.memory_read_enable)
      bus.memory_read_data <= mem[bus.memory_addr];
  end

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int re_tot = 0;
  int we_tot = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.memory_read_enable && bus.memory_write_enable) viol++;
      if (!busy && (bus.memory_read_enable || bus.memory_write_enable)) viol++;
      if (bus.memory_read_enable) re_tot++;
      if (bus.memory_write_enable) we_tot++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic kick(input logic m, input logic [7:0] s,
                      input logic [7:0] d, input logic [7:0] l,
                      input logic [7:0] f);
    mode       = m;
    src_addr   = s;
    dst_addr   = d;
    length     = l;
    fill_value = f;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  int n_busy;
  int n_we;
  int t_done;

  task automatic wait_done(input string tag);
    n_busy = 0;
    n_we   = 0;
    t_done = -1;
    for (int i = 0; i < 1000; i++) begin
      if (busy) n_busy++;
      if (bus.memory_write_enable) n_we++;
      if (done) begin
        t_done = i;
        break;
      end
      tick();
    end
    chk({tag, "_timeout"}, 32'(t_done >= 0), 32'd1);
  endtask

  int r0;
  int w0;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    length     = '0;
    fill_value = '0;
    tb_we      = 1'b0;
    tb_wa      = '0;
    tb_wd      = '0;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);

    chk("rst_addr",  32'(bus.memory_addr), 32'h0);
    chk("rst_re",    32'(bus.memory_read_enable), 32'h0);
    chk("rst_we",    32'(bus.memory_write_enable), 32'h0);
    chk("rst_wdata", 32'(bus.memory_write_data), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_csum",  32'(checksum), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // copy 4 bytes 0x10 -> 0x80
    poke(8'h10, 8'h01);
    poke(8'h11, 8'h02);
    poke(8'h12, 8'h03);
    poke(8'h13, 8'h04);
    kick(1'b0, 8'h10, 8'h80, 8'd4, 8'h00);
    wait_done("copy");
    chk("copy_busy", 32'(n_busy), 32'd12);
    chk("copy_tdone", 32'(t_done), 32'd12);
    chk("copy_nwe", 32'(n_we), 32'd4);
    chk("copy_csum", 32'(checksum), 32'h0A);
    tick();
    chk("copy_done_once", 32'(done), 32'h0);
    chk("copy_mem", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]},
        32'h01020304);

    // fill with wrap across 0xFF
    kick(1'b1, 8'h00, 8'hFE, 8'd3, 8'hA5);
    wait_done("fill");
    chk("fill_busy", 32'(n_busy), 32'd3);
    chk("fill_tdone", 32'(t_done), 32'd3);
    chk("fill_nwe", 32'(n_we), 32'd3);
    chk("fill_csum", 32'(checksum), 32'hEF);
    chk("fill_mem", {8'h00, mem[8'hFE], mem[8'hFF], mem[8'h00]},
        32'h00A5A5A5);

    // zero length, both modes
    tick();
    r0 = re_tot;
    w0 = we_tot;
    kick(1'b1, 8'h00, 8'h90, 8'd0, 8'h77);
    wait_done("zfill");
    chk("zfill_tdone", 32'(t_done), 32'd0);
    chk("zfill_csum", 32'(checksum), 32'h0);
    tick();
    kick(1'b0, 8'h10, 8'h90, 8'd0, 8'h00);
    wait_done("zcopy");
    chk("zcopy_tdone", 32'(t_done), 32'd0);
    chk("zcopy_busy", 32'(n_busy), 32'd0);
    tick();
    tick();
    chk("zero_busy_after", 32'(busy), 32'h0);
    chk("zero_no_strobes", 32'((re_tot - r0) + (we_tot - w0)), 32'd0);
    chk("zero_mem90", 32'(mem[8'h90]), 32'h00);

    // start held high through a len=2 copy
    poke(8'h30, 8'hAA);
    poke(8'h31, 8'h55);
    mode       = 1'b0;
    src_addr   = 8'h30;
    dst_addr   = 8'h40;
    length     = 8'd2;
    fill_value = 8'h00;
    start      = 1'b1;
    tick();
    mode       = 1'b1;
    src_addr   = 8'h00;
    dst_addr   = 8'h60;
    length     = 8'd1;
    fill_value = 8'h5A;
    wait_done("hold");
    chk("hold_busy", 32'(n_busy), 32'd6);
    chk("hold_tdone", 32'(t_done), 32'd6);
    chk("hold_csum", 32'(checksum), 32'hFF);
    chk("hold_mem", {16'h0, mem[8'h40], mem[8'h41]}, 32'h0000AA55);
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'h1);
    chk("restart_we", 32'(bus.memory_write_enable), 32'h1);
    chk("restart_addr", 32'(bus.memory_addr), 32'h60);
    wait_done("restart");
    chk("restart_tdone", 32'(t_done), 32'd1);
    chk("restart_csum", 32'(checksum), 32'h5A);
    chk("restart_mem", 32'(mem[8'h60]), 32'h5A);

    // asynchronous reset in cycle 5 of a len=4 copy
    tick();
    poke(8'h50, 8'h61);
    poke(8'h51, 8'h62);
    poke(8'h52, 8'h63);
    poke(8'h53, 8'h64);
    kick(1'b0, 8'h50, 8'h70, 8'd4, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs",
        {5'h0, bus.memory_addr, bus.memory_read_enable,
         bus.memory_write_enable, bus.memory_write_data,
         busy, done, checksum},
        32'h0);
    tick();
    chk("rst_mid_mem0", 32'(mem[8'h70]), 32'h61);
    chk("rst_mid_mem1", 32'(mem[8'h71]), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    kick(1'b0, 8'h50, 8'h71, 8'd1, 8'h00);
    wait_done("post_rst");
    chk("post_rst_tdone", 32'(t_done), 32'd3);
    chk("post_rst_csum", 32'(checksum), 32'h61);
    chk("post_rst_mem", 32'(mem[8'h71]), 32'h61);

    // overlapping ascending copy
    tick();
    poke(8'h20, 8'h11);
    poke(8'h21, 8'h22);
    poke(8'h22, 8'h33);
    poke(8'h23, 8'h44);
    kick(1'b0, 8'h20, 8'h21, 8'd3, 8'h00);
    wait_done("overlap");
    chk("overlap_csum", 32'(checksum), 32'h33);
    chk("overlap_mem", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]},
        32'h11111111);
    tick();
    tick();
    chk("strobe_rules", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
